proc_run_trace: RTL and testbench

- Synthesizable run-control and trace-capture unit that sits beside the single-cycle Processor.
- Replaces hard-coded bench sequencing with parametrised logic:
  - generates the core reset pulse
  - gates core execution
  - halts on a cycle limit, a PC breakpoint or an external stop
  - records retired PC/instruction/register-write into a circular buffer that is read oldest-first
- Used both in simulation benches and for on-board debug.

---
 rtl/proc_debug_pkg.sv | 33 +++
 rtl/trace_ring_buf.sv | 70 +++++++
 rtl/proc_run_trace.sv | 157 +++++++++++++++
 tb/tb_proc_run_trace.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_debug_pkg.sv
// Shared types for the processor run-control / trace unit.
// The trace entry carries register-write fields only when PROC_TRACE_REGWRITE_EN is defined.
package proc_debug_pkg;

  localparam int unsigned TRACE_XLEN = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned CYCLE_W    = 32;
  localparam int unsigned CAUSE_W    = 2;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } run_state_e;

  localparam logic [CAUSE_W-1:0] HC_NONE  = 2'b00;
  localparam logic [CAUSE_W-1:0] HC_LIMIT = 2'b01;
  localparam logic [CAUSE_W-1:0] HC_BP    = 2'b10;
  localparam logic [CAUSE_W-1:0] HC_STOP  = 2'b11;

  // Datapath fields are sized for the widest supported XLEN and zero-extended.
  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [INSTR_W-1:0]    instr;
`ifdef PROC_TRACE_REGWRITE_EN
    logic                  we;
    logic [REG_W-1:0]      da;
    logic [TRACE_XLEN-1:0] data;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_buf.sv
// DEPTH-entry circular trace store with saturating fill count, wrap flag and
// oldest-first read mapping. Storage itself is never reset.
module trace_ring_buf
  import proc_debug_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic          clr_i,
  input  trace_entry_t  wr_entry_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [CW-1:0] count_o,
  output logic          wrapped_o,
  output trace_entry_t  rd_entry_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrapped_q, wrapped_d;
  logic          full;
  logic [AW-1:0] rd_phys;
  trace_entry_t  mem_q [DEPTH];

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (clr_i) begin
      wr_ptr_d  = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
    end else if (wr_en_i) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      count_d   = full ? count_q : count_q + CW'(1);
      wrapped_d = wrapped_q | full;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  // Once wrapped, the write pointer addresses the oldest surviving entry.
  assign rd_phys    = (wrapped_q ? wr_ptr_q : AW'(0)) + rd_idx_i;
  assign rd_entry_o = (CW'(rd_idx_i) < count_q) ? mem_q[rd_phys] : '0;

  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;

endmodule

// File: rtl/proc_run_trace.sv
// Run-control and trace capture beside the single-cycle Processor: core reset
// pulse, run gating, halt on stop/breakpoint/cycle limit. Option: PROC_TRACE_REGWRITE_EN.
module proc_run_trace
  import proc_debug_pkg::*;
#(
  parameter  int unsigned XLEN         = 64,
  parameter  int unsigned DEPTH        = 16,
  parameter  int unsigned RESET_CYCLES = 1,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned CW           = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        max_cycles,
  input  logic               bp_en,
  input  logic [XLEN-1:0]    bp_pc,
  input  logic [XLEN-1:0]    pc,
  input  logic [31:0]        instr,
  input  logic               rf_we,
  input  logic [4:0]         rf_da,
  input  logic [XLEN-1:0]    rf_data,
  output logic               core_reset,
  output logic               core_run,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [31:0]        cycle_count,
  output logic [CW-1:0]      trace_count,
  output logic               trace_wrapped,
  input  logic [AW-1:0]      rd_idx,
  output logic [XLEN-1:0]    rd_pc,
  output logic [31:0]        rd_instr,
  output logic               rd_we,
  output logic [4:0]         rd_da,
  output logic [XLEN-1:0]    rd_data
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 rec, clr;
  logic                 bp_hit, lim_hit;
  trace_entry_t         wr_entry, rd_entry;

  assign bp_hit  = bp_en && (pc == bp_pc);
  assign lim_hit = (max_cycles != 32'd0) && ((cycle_q + 32'd1) == max_cycles);

  // Next-state, counters and halt priority (stop > breakpoint > limit).
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_q;
    cause_d = cause_q;
    rec     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        rec = 1'b1;
        if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
        if (stop) begin
          state_d = HALTED;
          cause_d = HC_STOP;
        end else if (bp_hit) begin
          state_d = HALTED;
          cause_d = HC_BP;
        end else if (lim_hit) begin
          state_d = HALTED;
          cause_d = HC_LIMIT;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = HOLD;
          hold_d  = '0;
          cycle_d = '0;
          cause_d = HC_NONE;
          clr     = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      hold_q  <= '0;
      cycle_q <= '0;
      cause_q <= HC_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cycle_q <= cycle_d;
      cause_q <= cause_d;
    end
  end

  assign core_reset  = (state_q == HOLD);
  assign core_run    = (state_q == RUN);
  assign halted      = (state_q == HALTED);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = TRACE_XLEN'(pc);
    wr_entry.instr = instr;
`ifdef PROC_TRACE_REGWRITE_EN
    wr_entry.we    = rf_we;
    wr_entry.da    = rf_da;
    wr_entry.data  = TRACE_XLEN'(rf_data);
`endif
  end

  trace_ring_buf #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i      (clock),
    .rst_ni     (reset),
    .wr_en_i    (rec),
    .clr_i      (clr),
    .wr_entry_i (wr_entry),
    .rd_idx_i   (rd_idx),
    .count_o    (trace_count),
    .wrapped_o  (trace_wrapped),
    .rd_entry_o (rd_entry)
  );

  assign rd_pc    = XLEN'(rd_entry.pc);
  assign rd_instr = rd_entry.instr;

`ifdef PROC_TRACE_REGWRITE_EN
  assign rd_we   = rd_entry.we;
  assign rd_da   = rd_entry.da;
  assign rd_data = XLEN'(rd_entry.data);
`else
  // Register-write inputs are not captured in this build.
  logic unused_rf;
  assign unused_rf = ^{rf_we, rf_da, rf_data};
  assign rd_we     = 1'b0;
  assign rd_da     = '0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_proc_run_trace.sv
// Directed self-checking bench for proc_run_trace with a simple PC-stepping core model.
module tb_proc_run_trace;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            stop  = 1'b0;
  logic [31:0]     max_cycles = 32'd0;
  logic            bp_en = 1'b0;
  logic [XLEN-1:0] bp_pc = '0;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic            rf_we;
  logic [4:0]      rf_da;
  logic [XLEN-1:0] rf_data;
  logic            core_reset, core_run, halted, trace_wrapped;
  logic [1:0]      halt_cause;
  logic [31:0]     cycle_count;
  logic [CW-1:0]   trace_count;
  logic [AW-1:0]   rd_idx = '0;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [31:0]     rd_instr;
  logic            rd_we;
  logic [4:0]      rd_da;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] core_idx;
  logic        rw_enable = 1'b0;

  always #5 clock = ~clock;

  // Core model: PC = 4 * retired count, cleared while core_reset is high.
  always @(posedge clock) begin
    if (core_reset)    core_idx <= 32'd0;
    else if (core_run) core_idx <= core_idx + 32'd1;
  end

  assign pc      = XLEN'(core_idx) * 4;
  assign instr   = 32'h1000_0000 | core_idx;
  assign rf_we   = rw_enable && (core_idx == 32'd3);
  assign rf_da   = rf_we ? 5'd9 : 5'd0;
  assign rf_data = rf_we ? XLEN'(32'hDEAD) : '0;

  proc_run_trace #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .max_cycles(max_cycles), .bp_en(bp_en), .bp_pc(bp_pc),
    .pc(pc), .instr(instr), .rf_we(rf_we), .rf_da(rf_da), .rf_data(rf_data),
    .core_reset(core_reset), .core_run(core_run), .halted(halted),
    .halt_cause(halt_cause), .cycle_count(cycle_count),
    .trace_count(trace_count), .trace_wrapped(trace_wrapped),
    .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_we(rd_we), .rd_da(rd_da), .rd_data(rd_data)
  );

  task automatic run_until_halt(input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      @(negedge clock);
      if (halted === 1'b1) ok = 1'b1;
      i++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; max_cycles = 32'd100;
    repeat (2) @(negedge clock);
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (core_run !== 1'b0) begin n_fail++; $display("FAIL rst_core_run: got %b expected 0", core_run); end
    n_checks++; if (halted !== 1'b0 || halt_cause !== 2'b00) begin n_fail++; $display("FAIL rst_halt: got %b/%b expected 0/00", halted, halt_cause); end
    n_checks++; if (cycle_count !== 32'd0 || trace_count !== 5'd0 || trace_wrapped !== 1'b0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d/%b expected 0/0/0", cycle_count, trace_count, trace_wrapped); end
    reset = 1'b1;
    #1;
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL hold_before_edge: got %b expected 1", core_reset); end
    @(negedge clock);
    n_checks++; if (core_reset !== 1'b0 || core_run !== 1'b1) begin n_fail++; $display("FAIL hold_one_edge: got rst=%b run=%b expected 0/1", core_reset, core_run); end
    n_checks++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL run_start_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_cycle_limit();
    bit ok;
    run_until_halt(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL limit_timeout: halted got %b expected 1", halted); end
    n_checks++; if (halt_cause !== 2'b01) begin n_fail++; $display("FAIL limit_cause: got %b expected 01", halt_cause); end
    n_checks++; if (cycle_count !== 32'd100) begin n_fail++; $display("FAIL limit_cycles: got %0d expected 100", cycle_count); end
    n_checks++; if (trace_count !== 5'd16 || trace_wrapped !== 1'b1) begin n_fail++; $display("FAIL limit_trace: got %0d/%b expected 16/1", trace_count, trace_wrapped); end
    rd_idx = 4'd0; #1;
    n_checks++; if (rd_pc !== 64'h150) begin n_fail++; $display("FAIL limit_oldest_pc: got %0h expected 150", rd_pc); end
    n_checks++; if (rd_instr !== 32'h1000_0054) begin n_fail++; $display("FAIL limit_oldest_instr: got %0h expected 10000054", rd_instr); end
    rd_idx = 4'd15; #1;
    n_checks++; if (rd_pc !== 64'h18C) begin n_fail++; $display("FAIL limit_newest_pc: got %0h expected 18c", rd_pc); end
    repeat (3) @(negedge clock);
    n_checks++; if (cycle_count !== 32'd100 || trace_count !== 5'd16 || halted !== 1'b1) begin n_fail++; $display("FAIL halted_frozen: got %0d/%0d/%b expected 100/16/1", cycle_count, trace_count, halted); end
  endtask

  task automatic test_restart();
    bit ok;
    max_cycles = 32'd5;
    pulse_start();
    n_checks++; if (halted !== 1'b0 || core_reset !== 1'b1) begin n_fail++; $display("FAIL restart_hold: got halted=%b rst=%b expected 0/1", halted, core_reset); end
    n_checks++; if (cycle_count !== 32'd0 || trace_count !== 5'd0 || halt_cause !== 2'b00 || trace_wrapped !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got %0d/%0d/%b/%b expected 0/0/00/0", cycle_count, trace_count, halt_cause, trace_wrapped); end
    @(negedge clock);
    n_checks++; if (core_run !== 1'b1 || core_reset !== 1'b0) begin n_fail++; $display("FAIL restart_run: got run=%b rst=%b expected 1/0", core_run, core_reset); end
    run_until_halt(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: halted got %b expected 1", halted); end
    n_checks++; if (cycle_count !== 32'd5 || trace_count !== 5'd5 || halt_cause !== 2'b01) begin n_fail++; $display("FAIL restart_limit: got %0d/%0d/%b expected 5/5/01", cycle_count, trace_count, halt_cause); end
    rd_idx = 4'd4; #1;
    n_checks++; if (rd_pc !== 64'h10) begin n_fail++; $display("FAIL restart_last_pc: got %0h expected 10", rd_pc); end
  endtask

  task automatic test_breakpoint();
    bit ok;
    max_cycles = 32'd0; bp_en = 1'b1; bp_pc = 64'h20;
    pulse_start();
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    run_until_halt(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: halted got %b expected 1", halted); end
    n_checks++; if (halt_cause !== 2'b10) begin n_fail++; $display("FAIL bp_cause: got %b expected 10", halt_cause); end
    n_checks++; if (cycle_count !== 32'd9 || trace_count !== 5'd9 || trace_wrapped !== 1'b0) begin n_fail++; $display("FAIL bp_counts: got %0d/%0d/%b expected 9/9/0", cycle_count, trace_count, trace_wrapped); end
    rd_idx = 4'd8; #1;
    n_checks++; if (rd_pc !== 64'h20) begin n_fail++; $display("FAIL bp_entry_pc: got %0h expected 20", rd_pc); end
    rd_idx = 4'd0; #1;
    n_checks++; if (rd_pc !== 64'h0 || rd_instr !== 32'h1000_0000) begin n_fail++; $display("FAIL bp_first_entry: got %0h/%0h expected 0/10000000", rd_pc, rd_instr); end
    rd_idx = 4'd9; #1;
    n_checks++; if (rd_pc !== '0 || rd_instr !== 32'd0 || rd_we !== 1'b0 || rd_da !== 5'd0 || rd_data !== '0) begin n_fail++; $display("FAIL bp_beyond_count: got %0h/%0h/%b/%0d/%0h expected all 0", rd_pc, rd_instr, rd_we, rd_da, rd_data); end
  endtask

  task automatic test_stop_priority();
    bit ok;
    bit found;
    int i;
    pulse_start();
    found = 1'b0;
    i = 0;
    while (!found && i < 40) begin
      @(negedge clock);
      if (core_run === 1'b1 && core_idx == 32'd8) found = 1'b1;
      i++;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stop_reach_bp: got core_idx=%0d expected 8", core_idx); end
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    ok = (halted === 1'b1);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_halted: got %b expected 1", halted); end
    n_checks++; if (halt_cause !== 2'b11 || cycle_count !== 32'd9) begin n_fail++; $display("FAIL stop_cause: got %b/%0d expected 11/9", halt_cause, cycle_count); end
  endtask

  task automatic test_reset_midrun();
    bit found;
    int i;
    bp_en = 1'b0; max_cycles = 32'd0;
    pulse_start();
    found = 1'b0;
    i = 0;
    while (!found && i < 40) begin
      @(negedge clock);
      if (cycle_count == 32'd7) found = 1'b1;
      i++;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midrun_reach7: got %0d expected 7", cycle_count); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (core_reset !== 1'b1 || core_run !== 1'b0) begin n_fail++; $display("FAIL midrun_async: got rst=%b run=%b expected 1/0", core_reset, core_run); end
    n_checks++; if (cycle_count !== 32'd0 || trace_count !== 5'd0) begin n_fail++; $display("FAIL midrun_clear: got %0d/%0d expected 0/0", cycle_count, trace_count); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL midrun_hold: got %b expected 1", core_reset); end
    @(negedge clock);
    n_checks++; if (core_run !== 1'b1 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL midrun_rerun: got run=%b cyc=%0d expected 1/0", core_run, cycle_count); end
    @(negedge clock);
    rd_idx = 4'd0; #1;
    n_checks++; if (cycle_count !== 32'd1 || trace_count !== 5'd1 || rd_pc !== 64'h0) begin n_fail++; $display("FAIL midrun_restart: got %0d/%0d/%0h expected 1/1/0", cycle_count, trace_count, rd_pc); end
    @(negedge clock); stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    n_checks++; if (halted !== 1'b1 || halt_cause !== 2'b11) begin n_fail++; $display("FAIL midrun_stop: got %b/%b expected 1/11", halted, halt_cause); end
  endtask

  task automatic test_regwrite();
    bit ok;
    logic       exp_we;
    logic [4:0] exp_da;
    logic [XLEN-1:0] exp_data;
`ifdef PROC_TRACE_REGWRITE_EN
    exp_we = 1'b1; exp_da = 5'd9; exp_data = XLEN'(32'hDEAD);
`else
    exp_we = 1'b0; exp_da = 5'd0; exp_data = '0;
`endif
    rw_enable = 1'b1; max_cycles = 32'd6;
    pulse_start();
    run_until_halt(50, ok);
    rw_enable = 1'b0;
    n_checks++; if (!ok || cycle_count !== 32'd6) begin n_fail++; $display("FAIL rw_halt: got %b/%0d expected 1/6", halted, cycle_count); end
    rd_idx = 4'd3; #1;
    n_checks++; if (rd_pc !== 64'hC) begin n_fail++; $display("FAIL rw_pc: got %0h expected c", rd_pc); end
    n_checks++; if (rd_we !== exp_we || rd_da !== exp_da || rd_data !== exp_data) begin n_fail++; $display("FAIL rw_fields: got %b/%0d/%0h expected %b/%0d/%0h", rd_we, rd_da, rd_data, exp_we, exp_da, exp_data); end
    rd_idx = 4'd2; #1;
    n_checks++; if (rd_we !== 1'b0 || rd_da !== 5'd0) begin n_fail++; $display("FAIL rw_other: got %b/%0d expected 0/0", rd_we, rd_da); end
  endtask

  initial begin
    test_reset();
    test_cycle_limit();
    test_restart();
    test_breakpoint();
    test_stop_priority();
    test_reset_midrun();
    test_regwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
